// File: rtl/parity_frame_receiver_if.sv
// Link bundle for the parity frame receiver: serial input side plus the
// deserialised payload, parity status and error count going to the consumer.
interface parity_frame_receiver_if #(
  parameter int FRAME_W   = 8,
  parameter int ERR_CNT_W = 8
);
  logic                 control;
  logic                 sin;
  logic                 sin_valid;
  logic                 frame_start;
  logic                 clear_err;
  logic [FRAME_W-2:0]   data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 busy;

  // Driver side: the serial link and the consumer of the payload
  modport master (
    output control, sin, sin_valid, frame_start, clear_err,
    input  data_out, data_valid, parity_err, err_count, busy
  );

  // Receiver side
  modport slave (
    input  control, sin, sin_valid, frame_start, clear_err,
    output data_out, data_valid, parity_err, err_count, busy
  );
endinterface

// File: rtl/parity_frame_receiver.sv
// Deserialises MSB-first {data, parity} frames from a bit-serial stream,
// checks parity against the mode latched at frame start, and keeps a
// saturating count of mismatching frames.
module parity_frame_receiver #(
  parameter int FRAME_W   = 8,
  parameter int ERR_CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  parity_frame_receiver_if.slave link
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [FRAME_W-2:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 mode_q, mode_d;
  logic [FRAME_W-2:0]   data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [FRAME_W-1:0]   frame;
  logic                 start_bit;
  logic                 complete;
  logic                 mismatch;

  // Decode the frame-level events seen this cycle
  always_comb begin
    frame     = {shift_q, link.sin};
    start_bit = link.sin_valid && link.frame_start;
    complete  = (state_q == SHIFT) && link.sin_valid && !link.frame_start &&
                (bit_cnt_q == LAST_CNT);
    mismatch  = complete && ((^frame) != mode_q);
  end

  // Next-state logic: a frame_start always (re)starts reception, a valid bit
  // in SHIFT either shifts in or completes the frame
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    mode_d       = mode_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    data_valid_d = 1'b0;
    err_count_d  = err_count_q;

    if (start_bit) begin
      state_d   = SHIFT;
      shift_d   = {{(FRAME_W-2){1'b0}}, link.sin};
      bit_cnt_d = CNT_W'(1);
      mode_d    = link.control;
    end else if (complete) begin
      state_d      = IDLE;
      shift_d      = '0;
      bit_cnt_d    = '0;
      data_out_d   = frame[FRAME_W-1:1];
      parity_err_d = mismatch;
      data_valid_d = 1'b1;
    end else if ((state_q == SHIFT) && link.sin_valid) begin
      shift_d   = {shift_q[FRAME_W-3:0], link.sin};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    if (mismatch) begin
      if (link.clear_err) begin
        err_count_d = ERR_CNT_W'(1);
      end else if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end else if (link.clear_err) begin
      err_count_d = '0;
    end
  end

  // State registers, cleared asynchronously so a mid-frame reset drops the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      mode_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      mode_q       <= mode_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      err_count_q  <= err_count_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    link.data_out   = data_out_q;
    link.data_valid = data_valid_q;
    link.parity_err = parity_err_q;
    link.err_count  = err_count_q;
    link.busy       = (state_q == SHIFT);
  end

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed bench for parity_frame_receiver. A second instance with a 2-bit
// error counter shares the same stimulus to exercise saturation.
module tb_parity_frame_receiver;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   dvSeen = 0;

  always #5 clk = ~clk;

  parity_frame_receiver_if #(.FRAME_W(8), .ERR_CNT_W(8)) bus ();
  parity_frame_receiver_if #(.FRAME_W(8), .ERR_CNT_W(2)) busSmall ();

  assign busSmall.control     = bus.control;
  assign busSmall.sin         = bus.sin;
  assign busSmall.sin_valid   = bus.sin_valid;
  assign busSmall.frame_start = bus.frame_start;
  assign busSmall.clear_err   = bus.clear_err;

  parity_frame_receiver #(.FRAME_W(8), .ERR_CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus.slave)
  );

  parity_frame_receiver #(.FRAME_W(8), .ERR_CNT_W(2)) dutSmall (
    .clk  (clk),
    .rst  (rst),
    .link (busSmall.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), return at the next negedge
  task automatic applyStimulus(input logic sv, input logic s, input logic fs);
    bus.sin_valid   = sv;
    bus.sin         = s;
    bus.frame_start = fs;
    @(posedge clk);
    @(negedge clk);
    if (bus.data_valid) dvSeen++;
  endtask

  task automatic sendFrame(input logic [7:0] f, input logic clrLast);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) bus.clear_err = clrLast;
      applyStimulus(1'b1, f[i], i == 7);
      bus.clear_err = 1'b0;
    end
  endtask

  task automatic checkFrame(input string tag, input logic [6:0] d,
                            input logic pe, input logic [7:0] cnt);
    checkOutput({tag, "_dv"},   32'(bus.data_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(bus.data_out),   32'(d));
    checkOutput({tag, "_perr"}, 32'(bus.parity_err), 32'(pe));
    checkOutput({tag, "_cnt"},  32'(bus.err_count),  32'(cnt));
  endtask

  initial begin
    logic [7:0] f;
    rst             = 1'b1;
    bus.control     = 1'b0;
    bus.sin         = 1'b0;
    bus.sin_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.clear_err   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_data", 32'(bus.data_out), 32'd0);
    checkOutput("rst_dv",   32'(bus.data_valid), 32'd0);
    checkOutput("rst_perr", 32'(bus.parity_err), 32'd0);
    checkOutput("rst_cnt",  32'(bus.err_count), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Even mode, 10101010, busy profile
    bus.control = 1'b0;
    f = 8'b10101010;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, f[i], i == 7);
      if (i == 7) checkOutput("even_busy_first", 32'(bus.busy), 32'd1);
      if (i == 1) begin
        checkOutput("even_busy_last", 32'(bus.busy), 32'd1);
        checkOutput("even_dv_early", 32'(bus.data_valid), 32'd0);
      end
    end
    checkFrame("even", 7'b1010101, 1'b0, 8'd0);
    checkOutput("even_busy_done", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("even_dv_pulse", 32'(bus.data_valid), 32'd0);
    checkOutput("even_hold", 32'(bus.data_out), 32'h55);

    // Odd mode, back-to-back frames
    bus.control = 1'b1;
    sendFrame(8'b10101011, 1'b0);
    checkFrame("odd1", 7'b1010101, 1'b0, 8'd0);
    sendFrame(8'b10101010, 1'b0);
    checkFrame("odd2", 7'b1010101, 1'b1, 8'd1);

    // Gapped partial frame aborted by a new frame_start
    bus.control = 1'b0;
    dvSeen = 0;
    f = 8'b10110011;
    for (int i = 7; i >= 3; i--) begin
      applyStimulus(1'b1, f[i], i == 7);
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b1, 1'b1);
    end
    sendFrame(8'b11000001, 1'b0);
    checkFrame("abort", 7'b1100000, 1'b1, 8'd2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_dv_count", 32'(dvSeen), 32'd1);

    // Saturation and clear (fresh counters)
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.control = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      sendFrame(8'b10000000, 1'b0);
      checkOutput("sat_wide", 32'(bus.err_count), 32'(n));
      checkOutput("sat_small", 32'(busSmall.err_count), 32'((n > 3) ? 3 : n));
    end
    checkOutput("sat_small_data", 32'(busSmall.data_out), 32'h40);
    sendFrame(8'b10000000, 1'b1);
    checkOutput("clr_mis_wide", 32'(bus.err_count), 32'd1);
    checkOutput("clr_mis_small", 32'(busSmall.err_count), 32'd1);
    bus.clear_err = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.clear_err = 1'b0;
    checkOutput("clr_alone_wide", 32'(bus.err_count), 32'd0);
    checkOutput("clr_alone_small", 32'(busSmall.err_count), 32'd0);

    // Asynchronous reset in the middle of a frame
    sendFrame(8'b10000000, 1'b0);
    checkFrame("pre_rst", 7'b1000000, 1'b1, 8'd1);
    f = 8'b11110000;
    for (int i = 7; i >= 4; i--) applyStimulus(1'b1, f[i], i == 7);
    checkOutput("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("arst_data", 32'(bus.data_out), 32'd0);
    checkOutput("arst_perr", 32'(bus.parity_err), 32'd0);
    checkOutput("arst_cnt",  32'(bus.err_count), 32'd0);
    checkOutput("arst_busy", 32'(bus.busy), 32'd0);
    checkOutput("arst_dv",   32'(bus.data_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sendFrame(8'b00000011, 1'b0);
    checkFrame("post_rst", 7'b0000001, 1'b0, 8'd0);

    // Mode latched at frame start; later control change ignored
    bus.control = 1'b0;
    f = 8'b10000000;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, f[i], i == 7);
      if (i == 5) bus.control = 1'b1;
    end
    checkFrame("latch", 7'b1000000, 1'b1, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
